sample_ctrl: RTL and testbench

Capture/readout sequencer for the 32-bit sample memory (m4k RAM with its self-incrementing/decrementing address counter).
- In idle it streams samples into memory continuously, forming a ring buffer of pre-trigger history.
- On trigger it writes a programmed number of post-trigger samples, then reads a programmed number of samples back.
- Each readout word is handed to the serial transmitter via a send/busy handshake.
- Sits between the trigger/sampler path, the memory wrapper, and the transmitter.

---
 rtl/sample_ctrl.sv | 118 +++++++++++
 tb/tb_sample_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ctrl.sv
// sample_ctrl: capture/readout sequencer for the sample memory.
// Idle streams samples into the ring buffer; a trigger writes delayCount+1
// more samples, then reads readCount+1 words back through a send/busy
// handshake. Optional macro SAMPLE_CTRL_ABORT_EN adds an abort input that
// returns the sequencer to IDLE on the next edge.
module sample_ctrl #(
    parameter int COUNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        validIn,
    input  logic [31:0] dataIn,
    input  logic        run,
    input  logic        wrSize,
    input  logic [31:0] configData,
    input  logic        busy,
    output logic        send,
    output logic [31:0] dataOut,
    output logic [31:0] memoryIn,
    input  logic [31:0] memoryOut,
    output logic        memoryWrite,
    output logic        memoryRead,
`ifdef SAMPLE_CTRL_ABORT_EN
    input  logic        abort,
`endif
    output logic        armed
);
    typedef enum logic [2:0] {IDLE, DELAY, READ, RWAIT, LOAD, XMIT} state_t;

    state_t state, state_nx;
    logic [COUNT_W-1:0] counter, counter_nx, delay_count, read_count;
    logic kill, capture;

`ifdef SAMPLE_CTRL_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    assign capture = (state == IDLE) || (state == DELAY);
    assign armed = (state == IDLE);

    // Next-state and sample/word counter; send high marks the first XMIT
    // cycle, which is taken unconditionally so the transmitter can raise busy.
    always_comb begin
        state_nx = state;
        counter_nx = counter;
        case (state)
            IDLE: begin
                counter_nx = '0;
                if (run) state_nx = DELAY;
            end
            DELAY: if (validIn) begin
                if (counter == delay_count) begin
                    state_nx = READ;
                    counter_nx = '0;
                end else begin
                    counter_nx = counter + 1'b1;
                end
            end
            READ: state_nx = RWAIT;
            RWAIT: state_nx = LOAD;
            LOAD: state_nx = XMIT;
            XMIT: if (!send && !busy) begin
                if (counter == read_count) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = READ;
                    counter_nx = counter + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (kill) begin
            state_nx = IDLE;
            counter_nx = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            counter <= '0;
        end else begin
            state <= state_nx;
            counter <= counter_nx;
        end
    end

    // Count registers, loadable only while waiting for a trigger.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay_count <= '0;
            read_count <= '0;
        end else if (wrSize && state == IDLE) begin
            delay_count <= configData[16 +: COUNT_W];
            read_count <= configData[0 +: COUNT_W];
        end
    end

    // Registered memory/transmitter strobes; dataOut holds between loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memoryWrite <= 1'b0;
            memoryIn <= '0;
            memoryRead <= 1'b0;
            send <= 1'b0;
            dataOut <= '0;
        end else begin
            memoryWrite <= !kill && capture && validIn;
            if (capture) memoryIn <= dataIn;
            memoryRead <= !kill && (state == READ);
            send <= !kill && (state == LOAD);
            if (state == LOAD) dataOut <= memoryOut;
        end
    end
endmodule

// File: tb/tb_sample_ctrl.sv
// tb_sample_ctrl: scoreboard bench for sample_ctrl (memory and transmitter models).
module tb_sample_ctrl;
    logic        clock = 0;
    logic        reset = 0;
    logic        validIn = 0;
    logic [31:0] dataIn = 0;
    logic        run = 0;
    logic        wrSize = 0;
    logic [31:0] configData = 0;
    logic        busy = 0;
    logic        send;
    logic [31:0] dataOut;
    logic [31:0] memoryIn;
    logic [31:0] memoryOut = 0;
    logic        memoryWrite;
    logic        memoryRead;
    logic        armed;
`ifdef SAMPLE_CTRL_ABORT_EN
    logic        abort = 0;
`endif

    int compared = 0;
    int mismatched = 0;
    int n_wr = 0, n_rd = 0, n_send = 0;
    int cyc = 0, last_rd = 0, last_send = -1, outstanding = 0;
    int hold = 0, busy_left = 0, rd_seq = 0;
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];

    sample_ctrl dut (
        .clock(clock),
        .reset(reset),
        .validIn(validIn),
        .dataIn(dataIn),
        .run(run),
        .wrSize(wrSize),
        .configData(configData),
        .busy(busy),
        .send(send),
        .dataOut(dataOut),
        .memoryIn(memoryIn),
        .memoryOut(memoryOut),
        .memoryWrite(memoryWrite),
        .memoryRead(memoryRead),
`ifdef SAMPLE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .armed(armed)
    );

    always #5 clock = ~clock;

    // Memory model: a read strobe yields a distinct word one cycle later,
    // then junk, so a mistimed capture is visible.
    always @(posedge clock) begin
        if (memoryRead) begin
            memoryOut <= 32'hC0DE_0000 + rd_seq;
            exp_rd.push_back(32'hC0DE_0000 + rd_seq);
            rd_seq++;
        end else begin
            memoryOut <= 32'hDEAD_BEEF ^ rd_seq;
        end
    end

    // Transmitter model: busy for `hold` cycles after each send.
    always @(posedge clock) begin
        if (send && hold > 0) begin
            busy <= 1'b1;
            busy_left <= hold - 1;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            busy <= 1'b0;
        end
    end

    // Output monitor: pops scoreboard entries as the DUT produces them.
    always @(negedge clock) begin
        if (!reset) begin
            cyc++;
            if (memoryWrite) begin
                n_wr++;
                compared++;
                if (exp_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL wr_unexpected memoryIn=%h none expected", memoryIn);
                end else begin
                    logic [31:0] e;
                    e = exp_wr.pop_front();
                    if (memoryIn !== e) begin
                        mismatched++;
                        $display("FAIL wr_data got %h exp %h", memoryIn, e);
                    end
                end
                compared++;
                if (memoryRead !== 1'b0) begin
                    mismatched++;
                    $display("FAIL rd_wr_overlap got memoryRead=%b exp 0", memoryRead);
                end
            end
            if (memoryRead) begin
                n_rd++;
                compared++;
                if (busy !== 1'b0 || outstanding != 0) begin
                    mismatched++;
                    $display("FAIL rd_guard got busy=%b outstanding=%0d exp 0/0", busy, outstanding);
                end
                if (last_send >= 0) begin
                    compared++;
                    if (cyc - last_send != hold + 3) begin
                        mismatched++;
                        $display("FAIL rd_gap got %0d exp %0d", cyc - last_send, hold + 3);
                    end
                end
                outstanding++;
                last_rd = cyc;
            end
            if (send) begin
                n_send++;
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL send_busy got busy=%b exp 0", busy);
                end
                compared++;
                if (cyc - last_rd != 2) begin
                    mismatched++;
                    $display("FAIL send_lat got %0d exp 2", cyc - last_rd);
                end
                compared++;
                if (exp_rd.size() == 0) begin
                    mismatched++;
                    $display("FAIL send_unexpected dataOut=%h none expected", dataOut);
                end else begin
                    logic [31:0] e;
                    e = exp_rd.pop_front();
                    if (dataOut !== e) begin
                        mismatched++;
                        $display("FAIL send_data got %h exp %h", dataOut, e);
                    end
                end
                outstanding--;
                last_send = cyc;
            end
            if (armed) last_send = -1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input logic [31:0] d);
        validIn = 1;
        dataIn = d;
        exp_wr.push_back(d);
        tick();
        validIn = 0;
    endtask

    task automatic load_cfg(input logic [31:0] c);
        configData = c;
        wrSize = 1;
        tick();
        wrSize = 0;
    endtask

    task automatic fire();
        run = 1;
        tick();
        run = 0;
    endtask

    task automatic wait_armed(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (armed === 1'b1) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        validIn = 1;
        dataIn = 32'h55;
        tick();
        validIn = 0;
        compared++;
        if ({send, memoryWrite, memoryRead} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_strobes got %b exp 000", {send, memoryWrite, memoryRead});
        end
        compared++;
        if (dataOut !== 32'h0 || memoryIn !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_data got %h/%h exp 0/0", dataOut, memoryIn);
        end
        compared++;
        if (armed !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_armed got %b exp 1", armed);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_idle_stream();
        int w0, r0;
        w0 = n_wr;
        r0 = n_rd;
        for (int i = 1; i <= 5; i++) sample(i);
        tick();
        tick();
        compared++;
        if (n_wr - w0 != 5 || exp_wr.size() != 0) begin
            mismatched++;
            $display("FAIL idle_writes got %0d exp 5", n_wr - w0);
        end
        compared++;
        if (n_rd != r0 || armed !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_state got reads=%0d armed=%b exp 0/1", n_rd - r0, armed);
        end
    endtask

    task automatic run_capture(input string nm, input logic [31:0] cfg, input int h);
        int w0, s0;
        bit ok;
        hold = h;
        load_cfg(cfg);
        w0 = n_wr;
        s0 = n_send;
        fire();
        compared++;
        if (armed !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_armed_low got %b exp 0", nm, armed);
        end
        for (int i = 0; i <= int'(cfg[31:16]); i++) sample(32'hA000_0000 + i);
        wait_armed(1000, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s_timeout got armed=%b exp 1", nm, armed);
        end
        tick();
        compared++;
        if (n_wr - w0 != int'(cfg[31:16]) + 1 || exp_wr.size() != 0) begin
            mismatched++;
            $display("FAIL %s_writes got %0d exp %0d", nm, n_wr - w0, int'(cfg[31:16]) + 1);
        end
        compared++;
        if (n_send - s0 != int'(cfg[15:0]) + 1 || exp_rd.size() != 0) begin
            mismatched++;
            $display("FAIL %s_sends got %0d exp %0d", nm, n_send - s0, int'(cfg[15:0]) + 1);
        end
    endtask

    task automatic test_capture_readout();
        run_capture("capture", 32'h0003_0001, 3);
    endtask

    task automatic test_busy_hold();
        run_capture("busy", 32'h0001_0002, 10);
    endtask

    task automatic test_min_config();
        run_capture("min", 32'h0000_0000, 0);
    endtask

`ifdef SAMPLE_CTRL_ABORT_EN
    task automatic test_abort();
        int w0, s0;
        bit ok;
        hold = 2;
        load_cfg(32'h0004_0001);
        w0 = n_wr;
        s0 = n_send;
        fire();
        sample(32'h11);
        sample(32'h22);
        validIn = 1;
        dataIn = 32'h33;
        abort = 1;
        tick();
        abort = 0;
        validIn = 0;
        compared++;
        if (armed !== 1'b1 || memoryWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_idle got armed=%b wr=%b exp 1/0", armed, memoryWrite);
        end
        fire();
        for (int i = 0; i < 4; i++) sample(32'h40 + i);
        compared++;
        if (armed !== 1'b0 || n_rd != 0 && memoryRead !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_restart got armed=%b exp 0", armed);
        end
        sample(32'h44);
        wait_armed(1000, ok);
        tick();
        compared++;
        if (!ok || n_wr - w0 != 7 || n_send - s0 != 2) begin
            mismatched++;
            $display("FAIL abort_counts got wr=%0d send=%0d exp 7/2", n_wr - w0, n_send - s0);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int r0, s0;
        bit seen;
        hold = 10;
        load_cfg(32'h0000_0002);
        fire();
        sample(32'hBEEF);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (send === 1'b1) seen = 1;
            else tick();
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL midreset_send got none exp send");
        end
        tick();
        tick();
        reset = 1;
        #1;
        compared++;
        if ({send, memoryWrite, memoryRead} !== 3'b000 || dataOut !== 32'h0 || memoryIn !== 32'h0) begin
            mismatched++;
            $display("FAIL midreset_outputs got %b %h %h exp 000 0 0", {send, memoryWrite, memoryRead}, dataOut, memoryIn);
        end
        compared++;
        if (armed !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_armed got %b exp 1", armed);
        end
        tick();
        tick();
        reset = 0;
        exp_rd.delete();
        outstanding = 0;
        r0 = n_rd;
        s0 = n_send;
        repeat (20) tick();
        compared++;
        if (n_rd != r0 || n_send != s0 || armed !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_quiet got reads=%0d sends=%0d exp 0/0", n_rd - r0, n_send - s0);
        end
    endtask

    initial begin
        test_reset();
        test_idle_stream();
        test_capture_readout();
        test_busy_hold();
        test_min_config();
`ifdef SAMPLE_CTRL_ABORT_EN
        test_abort();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
